// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the native memory bus utilities: arbiter state
// encoding, default bus widths and an index-width helper.
package bus_arbiter_rr_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int BUS_ADDR_WIDTH = 32;
    localparam int BUS_DATA_WIDTH = 32;
    localparam int BUS_STRB_WIDTH = 4;

    // Width needed to hold an index in 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request after i_last, wrapping
// modulo NUM_REQ. Kept standalone so a multi-slave crossbar can reuse it.
module rr_select #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [IDX_WIDTH-1:0] i_last,
    output logic [NUM_REQ-1:0]   o_pick,
    output logic [IDX_WIDTH-1:0] o_idx,
    output logic                 o_any
);

    always_comb begin
        int j;
        // NOTE: every output gets a default before the loop so no path through
        // this block leaves a value unassigned, which would infer a latch.
        o_pick = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        j      = 0;
        // Scan last+1 .. last+NUM_REQ; the wrap keeps indices below NUM_REQ
        // even when NUM_REQ is not a power of two.
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(i_last) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!o_any && i_req[j]) begin
                o_any     = 1'b1;
                o_pick[j] = 1'b1;
                o_idx     = IDX_WIDTH'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-to-1 round-robin arbiter for the valid/ready native memory bus. A grant is
// registered one cycle after a request and held until the slave completes.
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH  = BUS_DATA_WIDTH,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_MASTERS-1:0]            m_valid,
    output logic [NUM_MASTERS-1:0]            m_ready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS*STRB_WIDTH-1:0] m_wstrb,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
    output logic                              s_valid,
    input  logic                              s_ready,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    output logic [STRB_WIDTH-1:0]             s_wstrb,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    output logic [NUM_MASTERS-1:0]            grant
);

    localparam int IDX_WIDTH = clog2(NUM_MASTERS);

    arb_state_t             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [IDX_WIDTH-1:0]   r_owner;
    logic [IDX_WIDTH-1:0]   r_last;

    logic [NUM_MASTERS-1:0] w_pick;
    logic [IDX_WIDTH-1:0]   w_pick_idx;
    logic                   w_any_req;
    logic                   w_s_valid;
    logic [ADDR_WIDTH-1:0]  w_s_addr;
    logic [DATA_WIDTH-1:0]  w_s_wdata;
    logic [STRB_WIDTH-1:0]  w_s_wstrb;

    rr_select #(
        .NUM_REQ   (NUM_MASTERS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_select (
        .i_req  (m_valid),
        .i_last (r_last),
        .o_pick (w_pick),
        .o_idx  (w_pick_idx),
        .o_any  (w_any_req)
    );

    // Slave side is selected by the registered one-hot grant only: an idle
    // arbiter or a non-owner's request can never reach the slave.
    always_comb begin
        w_s_valid = 1'b0;
        w_s_addr  = '0;
        w_s_wdata = '0;
        w_s_wstrb = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) begin
                w_s_valid = m_valid[i];
                w_s_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_s_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_s_wstrb = m_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!resetn) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_last  <= IDX_WIDTH'(NUM_MASTERS - 1);
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any_req) begin
                        r_state <= ARB_BUSY;
                        r_grant <= w_pick;
                        r_owner <= w_pick_idx;
                    end
                end
                ARB_BUSY: begin
                    // A dropped owner request is an abort: release without
                    // advancing the round-robin pointer.
                    if (!w_s_valid) begin
                        r_state <= ARB_IDLE;
                        r_grant <= '0;
                    end else if (s_ready) begin
                        r_state <= ARB_IDLE;
                        r_grant <= '0;
                        r_last  <= r_owner;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign s_valid = w_s_valid;
    assign s_addr  = w_s_addr;
    assign s_wdata = w_s_wdata;
    assign s_wstrb = w_s_wstrb;
    assign grant   = r_grant;
    assign m_ready = s_ready ? r_grant : '0;
    assign m_rdata = {NUM_MASTERS{s_rdata}};

endmodule
